// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: arbiter FSM state encodings, bus owner encodings and the bus width.
// Ports:   none (package).

package mem_port_arbiter_pkg;

   localparam int BUS_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM shared SRAM-like port arbiter with watchdog
//
// Purpose: grants one of the IF (fetch) or MEM (load/store) stages onto the single
//          memory bus, data first, one transaction outstanding, and sequences the
//          addr_ok/data_ok handshake. A watchdog force-completes a stuck transaction.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   inst_req/inst_addr             fetch request (level) and address
//   inst_rdata/inst_valid          fetch data and one-cycle completion
//   data_req/wen/addr/wdata        load/store request (level), strobes, address, data
//   data_rdata/data_valid          load data and one-cycle completion
//   bus_req/wr/wstrb/addr/wdata    registered bus request
//   bus_addr_ok/data_ok/rdata      bus handshake and read data
//   stallreq_for_if/_mem           per-stage hold requests to the stall controller
//   bus_timeout                    sticky watchdog error flag

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inst_req,
   input  logic [BUS_W-1:0] inst_addr,
   output logic [BUS_W-1:0] inst_rdata,
   output logic             inst_valid,
   input  logic             data_req,
   input  logic [3:0]       data_wen,
   input  logic [BUS_W-1:0] data_addr,
   input  logic [BUS_W-1:0] data_wdata,
   output logic [BUS_W-1:0] data_rdata,
   output logic             data_valid,
   output logic             bus_req,
   output logic             bus_wr,
   output logic [3:0]       bus_wstrb,
   output logic [BUS_W-1:0] bus_addr,
   output logic [BUS_W-1:0] bus_wdata,
   input  logic             bus_addr_ok,
   input  logic             bus_data_ok,
   input  logic [BUS_W-1:0] bus_rdata,
   output logic             stallreq_for_if,
   output logic             stallreq_for_mem,
   output logic             bus_timeout
);

   arb_state_e       state_q, state_d;
   owner_e           owner_q, owner_d;
   logic [BUS_W-1:0] addr_q, addr_d;
   logic [BUS_W-1:0] wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic             wr_q, wr_d;
   logic [CNT_W-1:0] wdog_q, wdog_d;
   logic             timeout_q, timeout_d;

   logic             done;
   logic             forced;
   logic             wdog_hit;
   logic [BUS_W-1:0] resp_rdata;

   assign wdog_hit = (wdog_q == CNT_W'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         owner_q   <= OWN_NONE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wr_q      <= 1'b0;
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wr_q      <= wr_d;
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wr_d      = wr_q;
      timeout_d = timeout_q;
      wdog_d    = wdog_q;
      done      = 1'b0;
      forced    = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            // Data has priority so a pending load/store never starves behind fetches.
            if (data_req) begin
               owner_d = OWN_D;
               addr_d  = data_addr;
               wdata_d = data_wdata;
               wstrb_d = data_wen;
               wr_d    = |data_wen;
               state_d = ARB_ADDR;
            end else if (inst_req) begin
               owner_d = OWN_I;
               addr_d  = inst_addr;
               wdata_d = '0;
               wstrb_d = 4'b0000;
               wr_d    = 1'b0;
               state_d = ARB_ADDR;
            end
         end
         ARB_ADDR: begin
            if (bus_addr_ok && bus_data_ok) begin
               done = 1'b1;
            end else if (bus_addr_ok) begin
               state_d = ARB_DATA;
            end else if (wdog_hit) begin
               done   = 1'b1;
               forced = 1'b1;
            end
         end
         ARB_DATA: begin
            if (bus_data_ok) begin
               done = 1'b1;
            end else if (wdog_hit) begin
               done   = 1'b1;
               forced = 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (done) begin
         state_d = ARB_IDLE;
         owner_d = OWN_NONE;
      end
      if (forced) begin
         timeout_d = 1'b1;
      end

      // Watchdog measures time spent in the current busy state only.
      if ((state_d != state_q) || (state_q == ARB_IDLE)) begin
         wdog_d = '0;
      end else begin
         wdog_d = wdog_q + CNT_W'(1);
      end

      resp_rdata = forced ? '0 : bus_rdata;

      // A completion coinciding with reset is dropped: the transaction never happened.
      inst_valid = done && !rst && (owner_q == OWN_I);
      data_valid = done && !rst && (owner_q == OWN_D);
      inst_rdata = inst_valid ? resp_rdata : '0;
      data_rdata = data_valid ? resp_rdata : '0;

      stallreq_for_if  = inst_req & ~inst_valid;
      stallreq_for_mem = data_req & ~data_valid;
   end

   assign bus_req     = (state_q == ARB_ADDR);
   assign bus_wr      = wr_q;
   assign bus_wstrb   = wstrb_q;
   assign bus_addr    = addr_q;
   assign bus_wdata   = wdata_q;
   assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_valid;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_valid;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;
   logic        stallreq_for_if;
   logic        stallreq_for_mem;
   logic        bus_timeout;

   logic        rst_nx;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        is_d;
      logic        chk_rd;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];

   mem_port_arbiter #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_valid(inst_valid),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
      .stallreq_for_if(stallreq_for_if), .stallreq_for_mem(stallreq_for_mem),
      .bus_timeout(bus_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs just after the rising edge, return at the falling edge.
   task automatic step(input logic ireq, input logic dreq, input logic aok,
                       input logic dok, input logic [31:0] rd);
      @(posedge clk);
      #1;
      rst         = rst_nx;
      inst_req    = ireq;
      data_req    = dreq;
      bus_addr_ok = aok;
      bus_data_ok = dok;
      bus_rdata   = rd;
      @(negedge clk);
   endtask

   task automatic push(input logic is_d, input logic chk_rd, input logic [31:0] rd);
      exp_t e;
      e.is_d   = is_d;
      e.chk_rd = chk_rd;
      e.rdata  = rd;
      exp_q.push_back(e);
   endtask

   // Monitor: every completion pulse is matched against the oldest expected response.
   always @(negedge clk) begin
      if (inst_valid && data_valid) begin
         chk("both_valid", 32'(inst_valid & data_valid), 32'd0);
      end else if (inst_valid || data_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", {31'd0, data_valid}, {31'd0, inst_valid} ^ 32'd1);
            chk("unexpected_valid_any", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_owner_is_d", {31'd0, data_valid}, {31'd0, e.is_d});
            if (e.chk_rd)
               chk("sb_rdata", data_valid ? data_rdata : inst_rdata, e.rdata);
         end
      end
   end

   initial begin
      rst = 1'b1; rst_nx = 1'b1;
      inst_req = 0; inst_addr = '0; data_req = 0; data_wen = '0;
      data_addr = '0; data_wdata = '0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;

      // Reset state
      step(0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wr_wstrb", {27'd0, bus_wr, bus_wstrb}, 32'd0);
      chk("rst_valids", {30'd0, inst_valid, data_valid}, 32'd0);
      chk("rst_timeout", {31'd0, bus_timeout}, 32'd0);
      rst_nx = 1'b0;
      step(0, 0, 0, 0, 32'h0);

      // Fetch only: addr_ok in cycle 2, data_ok in cycle 4
      inst_addr = 32'hBFC00000;
      push(1'b0, 1'b1, 32'h24080001);
      step(1, 0, 0, 0, 32'h0);
      chk("f_c0_bus_req", {31'd0, bus_req}, 32'd0);
      chk("f_c0_stall_if", {31'd0, stallreq_for_if}, 32'd1);
      step(1, 0, 0, 0, 32'h0);
      chk("f_c1_bus_req", {31'd0, bus_req}, 32'd1);
      chk("f_c1_bus_addr", bus_addr, 32'hBFC00000);
      chk("f_c1_wr_wstrb", {27'd0, bus_wr, bus_wstrb}, 32'd0);
      chk("f_c1_stall_if", {31'd0, stallreq_for_if}, 32'd1);
      step(1, 0, 1, 0, 32'h0);
      chk("f_c2_bus_req", {31'd0, bus_req}, 32'd1);
      step(1, 0, 0, 0, 32'h0);
      chk("f_c3_bus_req", {31'd0, bus_req}, 32'd0);
      chk("f_c3_stall_if", {31'd0, stallreq_for_if}, 32'd1);
      step(1, 0, 0, 1, 32'h24080001);
      chk("f_c4_stall_if", {31'd0, stallreq_for_if}, 32'd0);
      step(0, 0, 0, 0, 32'h0);
      chk("f_c5_bus_req", {31'd0, bus_req}, 32'd0);

      // Simultaneous: D first (same-cycle addr_ok/data_ok), then I
      data_addr = 32'h80000010; data_wen = 4'b0000; inst_addr = 32'h00400000;
      push(1'b1, 1'b1, 32'h11111111);
      push(1'b0, 1'b1, 32'h22222222);
      step(1, 1, 0, 0, 32'h0);
      chk("s_c0_stall_if", {31'd0, stallreq_for_if}, 32'd1);
      chk("s_c0_stall_mem", {31'd0, stallreq_for_mem}, 32'd1);
      step(1, 1, 1, 1, 32'h11111111);
      chk("s_c1_bus_addr_d", bus_addr, 32'h80000010);
      chk("s_c1_bus_req", {31'd0, bus_req}, 32'd1);
      chk("s_c1_stall_mem", {31'd0, stallreq_for_mem}, 32'd0);
      chk("s_c1_stall_if", {31'd0, stallreq_for_if}, 32'd1);
      step(1, 0, 0, 0, 32'h0);
      chk("s_c2_bus_req_one_cycle", {31'd0, bus_req}, 32'd0);
      chk("s_c2_stall_if", {31'd0, stallreq_for_if}, 32'd1);
      step(1, 0, 1, 1, 32'h22222222);
      chk("s_c3_bus_addr_i", bus_addr, 32'h00400000);
      chk("s_c3_bus_req", {31'd0, bus_req}, 32'd1);
      step(0, 0, 0, 0, 32'h0);
      chk("s_c4_bus_req", {31'd0, bus_req}, 32'd0);

      // Store
      data_addr = 32'h80000020; data_wen = 4'b0011; data_wdata = 32'h1234ABCD;
      push(1'b1, 1'b0, 32'h0);
      step(0, 1, 0, 0, 32'h0);
      step(0, 1, 0, 0, 32'h0);
      chk("st_wr", {31'd0, bus_wr}, 32'd1);
      chk("st_wstrb", {28'd0, bus_wstrb}, 32'h3);
      chk("st_wdata_c1", bus_wdata, 32'h1234ABCD);
      chk("st_addr", bus_addr, 32'h80000020);
      step(0, 1, 0, 0, 32'h0);
      chk("st_wdata_c2", bus_wdata, 32'h1234ABCD);
      chk("st_bus_req_c2", {31'd0, bus_req}, 32'd1);
      step(0, 1, 1, 0, 32'h0);
      chk("st_wdata_c3", bus_wdata, 32'h1234ABCD);
      step(0, 1, 0, 0, 32'h0);
      chk("st_data_bus_req", {31'd0, bus_req}, 32'd0);
      chk("st_stall_mem", {31'd0, stallreq_for_mem}, 32'd1);
      step(0, 1, 0, 1, 32'hDEADBEEF);
      chk("st_done_stall_mem", {31'd0, stallreq_for_mem}, 32'd0);
      step(0, 0, 0, 0, 32'h0);

      // Timeout (TIMEOUT_CYC=4): 4 stalled ADDR cycles, forced completion in the 5th
      inst_addr = 32'h00000100; data_wen = 4'b0000;
      push(1'b0, 1'b1, 32'h0);
      step(1, 0, 0, 0, 32'hFFFFFFFF);
      chk("to_pre_flag", {31'd0, bus_timeout}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 32'hFFFFFFFF);
         chk("to_addr_bus_req", {31'd0, bus_req}, 32'd1);
         chk("to_addr_stall_if", {31'd0, stallreq_for_if}, 32'd1);
      end
      step(1, 0, 0, 0, 32'hFFFFFFFF);
      chk("to_fire_stall_if", {31'd0, stallreq_for_if}, 32'd0);
      step(0, 0, 0, 0, 32'h0);
      chk("to_flag_set", {31'd0, bus_timeout}, 32'd1);
      chk("to_bus_req_idle", {31'd0, bus_req}, 32'd0);
      data_addr = 32'h00000200;
      push(1'b1, 1'b1, 32'h55AA55AA);
      step(0, 1, 0, 0, 32'h0);
      step(0, 1, 1, 1, 32'h55AA55AA);
      chk("to_next_addr", bus_addr, 32'h00000200);
      step(0, 0, 0, 0, 32'h0);
      chk("to_flag_sticky", {31'd0, bus_timeout}, 32'd1);

      // Reset in DATA: no valid, everything back to zero
      data_addr = 32'h00000300;
      step(0, 1, 0, 0, 32'h0);
      step(0, 1, 1, 0, 32'h0);
      step(0, 1, 0, 0, 32'h0);
      chk("rd_in_data", {31'd0, bus_req}, 32'd0);
      rst_nx = 1'b1;
      step(0, 1, 0, 1, 32'h77777777);
      chk("rd_no_valid_stall_mem", {31'd0, stallreq_for_mem}, 32'd1);
      chk("rd_no_valid_rdata", data_rdata, 32'd0);
      rst_nx = 1'b0;
      step(0, 0, 0, 0, 32'h0);
      chk("rd_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rd_bus_addr", bus_addr, 32'd0);
      chk("rd_bus_wdata", bus_wdata, 32'd0);
      chk("rd_wr_wstrb", {27'd0, bus_wr, bus_wstrb}, 32'd0);
      chk("rd_timeout_cleared", {31'd0, bus_timeout}, 32'd0);

      // Served normally after reset
      inst_addr = 32'h00000400;
      push(1'b0, 1'b1, 32'hCAFEF00D);
      step(1, 0, 0, 0, 32'h0);
      step(1, 0, 1, 1, 32'hCAFEF00D);
      chk("post_rst_addr", bus_addr, 32'h00000400);
      step(0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single SRAM-like memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Grants one requester at a time, with one outstanding transaction, and data given priority over instruction.
- Registers the granted request onto the bus and sequences the addr_ok/data_ok handshake.
- Raises per-stage stall requests that feed the pipeline stall controller alongside stallreq_for_ex/stallreq_for_load.

Parameters:
- TIMEOUT_CYC, 255: cycles without an expected handshake before the transaction is force-completed.
- CNT_W, 8: width of the watchdog counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- inst_req  in  1  IF fetch request, level, held until inst_valid
- inst_addr  in  32  fetch address
- inst_rdata  out  32  fetch data, valid with inst_valid
- inst_valid  out  1  one-cycle fetch completion
- data_req  in  1  MEM access request, level, held until data_valid
- data_wen  in  4  byte write enables; 0 = load
- data_addr  in  32  access address
- data_wdata  in  32  store data
- data_rdata  out  32  load data, valid with data_valid
- data_valid  out  1  one-cycle access completion
- bus_req  out  1  bus request
- bus_wr  out  1  1 = write
- bus_wstrb  out  4  byte strobes
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_addr_ok  in  1  address accepted this cycle
- bus_data_ok  in  1  response this cycle
- bus_rdata  in  32  read data, valid with bus_data_ok
- stallreq_for_if  out  1  IF must hold
- stallreq_for_mem  out  1  MEM must hold
- bus_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset values: state IDLE, owner none, watchdog counter 0. All bus outputs are 0, both valids are 0, both rdata outputs are 0, bus_timeout is 0.
- rst has precedence over everything. Reset mid-transaction drops the transaction and emits no valid. The bus is assumed reset in the same cycle.
- FSM states are IDLE, ADDR and DATA.
- IDLE:
  - If data_req is high: grant D.
  - Else if inst_req is high: grant I.
  - On grant, latch addr, wdata, wstrb and wr into bus registers, and go to ADDR. For I, wr=0 and wstrb=0. For D, wr = |data_wen.
  - With no request, stay in IDLE.
  - Grant is decided at the clock edge, so bus_req rises the cycle after the request at the earliest.
- ADDR:
  - bus_req=1 and the bus registers are held stable.
  - If bus_addr_ok and bus_data_ok are both high: complete the transaction and go to IDLE.
  - Else if bus_addr_ok is high: go to DATA, and bus_req drops on the next cycle.
  - Else stay in ADDR.
- DATA:
  - bus_req=0.
  - If bus_data_ok is high: complete and go to IDLE.
  - bus_data_ok outside DATA or ADDR is ignored.
- Completion:
  - The owner's valid is asserted combinationally in the completing cycle. The owner's rdata = bus_rdata in that cycle; for writes it is don't-care.
  - The non-owner's valid stays 0.
  - Next grant can happen on the cycle after completion. Back-to-back re-arbitration again prefers D.
- Stall requests, combinational:
  - stallreq_for_if = inst_req & ~inst_valid
  - stallreq_for_mem = data_req & ~data_valid
- Request rules:
  - A requester must not change its addr/wdata while its req is high and it is not yet complete. The arbiter uses latched copies in any case.
  - A request deasserted before grant is simply not served. A request deasserted after grant still completes on the bus; its valid pulse is generated and ignored.
- Watchdog:
  - Counts in ADDR/DATA and clears on any state change.
  - On reaching TIMEOUT_CYC: force-complete with rdata=0 and valid=1 to the owner, set bus_timeout, go to IDLE.
  - bus_timeout is cleared only by rst.

Decomposition:
- Add to lib/defines.vh: state encodings (ARB_IDLE, ARB_ADDR, ARB_DATA), owner encodings (OWN_NONE, OWN_I, OWN_D), and the bus width constant.
- No sub-module needed; the watchdog is an inline counter.

Test Plan:
- Fetch only: inst_req=1, inst_addr=0xBFC00000, addr_ok at cycle 2, data_ok=1 with rdata=0x24080001 at cycle 4 → bus_addr=0xBFC00000, wr=0, inst_valid=1 and inst_rdata=0x24080001 in cycle 4 only, stallreq_for_if high cycles 0-3.
- Simultaneous requests: inst_req and data_req (load, addr 0x80000010) both rise in cycle 0 → D granted first; I granted the cycle after data_valid; stallreq_for_if held throughout.
- Store: data_wen=4'b0011, wdata=0x1234ABCD → bus_wr=1, wstrb=0011, wdata stable through ADDR; data_valid on data_ok.
- addr_ok and data_ok in the same cycle → immediate completion, DATA never entered, bus_req 1 cycle.
- Timeout with TIMEOUT_CYC=4: addr_ok never arrives → valid=1 with rdata=0 after 4 cycles in ADDR, bus_timeout=1 and sticky, next request served normally.
- rst asserted in DATA → next cycle IDLE, all outputs 0, no valid pulse, bus_timeout=0.
